// File: rtl/kalman_gain_div_pkg.sv
// Shared types and constants for the Kalman gain divider.
// The optional clamp build is selected with KGAIN_DIV_CLAMP_EN.
package kalman_gain_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NUM_WIDTH_DEF = 32;
  localparam int FRAC_BITS_DEF = 24;

  localparam int TUSER_DBZ = 0;
  localparam int TUSER_SAT = 1;

  function automatic int iter_of(input int num_width, input int frac_bits);
    return num_width + frac_bits;
  endfunction

  function automatic logic [63:0] one_q(input int frac_bits);
    return 64'd1 << frac_bits;
  endfunction

  localparam int          ITER  = iter_of(NUM_WIDTH_DEF, FRAC_BITS_DEF);
  localparam logic [63:0] ONE_Q = one_q(FRAC_BITS_DEF);

endpackage

// File: rtl/kalman_gain_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract, emit a quotient bit.
module kalman_gain_div_step #(
  parameter int DEN_WIDTH = 32
) (
  input  logic [DEN_WIDTH:0]   rem,
  input  logic                 din,
  input  logic [DEN_WIDTH-1:0] den,
  output logic [DEN_WIDTH:0]   rem_next,
  output logic                 q_bit
);

  logic [DEN_WIDTH+1:0] shifted_s;
  logic [DEN_WIDTH+1:0] diff_s;

  assign shifted_s = {rem, din};
  assign diff_s    = shifted_s - {2'b00, den};

  // Restore the remainder when the trial subtraction would go negative
  always_comb begin
    rem_next = (DEN_WIDTH+1)'(shifted_s);
    q_bit    = 1'b0;
    if (shifted_s >= {2'b00, den}) begin
      rem_next = (DEN_WIDTH+1)'(diff_s);
      q_bit    = 1'b1;
    end else begin
      rem_next = (DEN_WIDTH+1)'(shifted_s);
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/kalman_gain_divider.sv
// Sequential fixed-point divider returning K = num/den for the Kalman filter.
// Define KGAIN_DIV_CLAMP_EN to saturate the gain at 1.0 instead of all ones.
module kalman_gain_divider
  import kalman_gain_div_pkg::*;
#(
  parameter int NUM_WIDTH  = NUM_WIDTH_DEF,
  parameter int DEN_WIDTH  = 32,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int QUOT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_WIDTH-1:0]  S_AXIS_NUM_tdata,
  input  logic [DEN_WIDTH-1:0]  S_AXIS_DEN_tdata,
  input  logic                  S_AXIS_DIV_tvalid,
  output logic                  S_AXIS_DIV_tready,
  output logic [QUOT_WIDTH-1:0] M_AXIS_K_tdata,
  output logic [1:0]            M_AXIS_K_tuser,
  output logic                  M_AXIS_K_tvalid,
  input  logic                  M_AXIS_K_tready
);

  localparam int ITER_N = iter_of(NUM_WIDTH, FRAC_BITS);
  localparam int CNT_W  = $clog2(ITER_N + 1);

`ifdef KGAIN_DIV_CLAMP_EN
  localparam logic [QUOT_WIDTH-1:0] SAT_VAL = QUOT_WIDTH'(one_q(FRAC_BITS));
`else
  localparam logic [QUOT_WIDTH-1:0] SAT_VAL = {QUOT_WIDTH{1'b1}};
`endif

  state_e                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [ITER_N-1:0]       dividend_r;
  logic [ITER_N-1:0]       quot_r;
  logic [DEN_WIDTH-1:0]    den_r;
  logic [DEN_WIDTH:0]      rem_r;
  logic                    dbz_r;
  logic                    tready_r;
  logic                    tvalid_r;
  logic [QUOT_WIDTH-1:0]   tdata_r;
  logic [1:0]              tuser_r;
  logic [DEN_WIDTH:0]      rem_next_s;
  logic                    q_bit_s;

  kalman_gain_div_step #(
    .DEN_WIDTH (DEN_WIDTH)
  ) u_step (
    .rem      (rem_r),
    .din      (dividend_r[ITER_N-1]),
    .den      (den_r),
    .rem_next (rem_next_s),
    .q_bit    (q_bit_s)
  );

  // Control FSM, iteration datapath and registered stream outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      dividend_r <= {ITER_N{1'b0}};
      quot_r     <= {ITER_N{1'b0}};
      den_r      <= {DEN_WIDTH{1'b0}};
      rem_r      <= {(DEN_WIDTH+1){1'b0}};
      dbz_r      <= 1'b0;
      tready_r   <= 1'b0;
      tvalid_r   <= 1'b0;
      tdata_r    <= {QUOT_WIDTH{1'b0}};
      tuser_r    <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tready_r <= 1'b1;
          if (S_AXIS_DIV_tvalid && tready_r) begin
            tready_r   <= 1'b0;
            dividend_r <= {S_AXIS_NUM_tdata, {FRAC_BITS{1'b0}}};
            den_r      <= S_AXIS_DEN_tdata;
            rem_r      <= {(DEN_WIDTH+1){1'b0}};
            quot_r     <= {ITER_N{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            dbz_r      <= (S_AXIS_DEN_tdata == {DEN_WIDTH{1'b0}});
            state_r    <= (S_AXIS_DEN_tdata == {DEN_WIDTH{1'b0}}) ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          rem_r      <= rem_next_s;
          quot_r     <= {quot_r[ITER_N-2:0], q_bit_s};
          dividend_r <= dividend_r << 1;
          cnt_r      <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(ITER_N - 1)) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          // First DONE cycle resolves the result; afterwards hold until the consumer takes it
          if (!tvalid_r) begin
            tvalid_r <= 1'b1;
            tuser_r  <= 2'b00;
            if (dbz_r) begin
              tdata_r            <= SAT_VAL;
              tuser_r[TUSER_DBZ] <= 1'b1;
            end else if (quot_r > ITER_N'(SAT_VAL)) begin
              tdata_r            <= SAT_VAL;
              tuser_r[TUSER_SAT] <= 1'b1;
            end else begin
              tdata_r <= quot_r[QUOT_WIDTH-1:0];
            end
          end else if (M_AXIS_K_tready) begin
            tvalid_r <= 1'b0;
            tready_r <= 1'b1;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          tready_r <= 1'b0;
          tvalid_r <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXIS_DIV_tready = tready_r;
  assign M_AXIS_K_tvalid   = tvalid_r;
  assign M_AXIS_K_tdata    = tdata_r;
  assign M_AXIS_K_tuser    = tuser_r;

endmodule

// File: tb/tb_kalman_gain_divider.sv
// Directed self-checking bench for kalman_gain_divider (default widths, ITER = 56).
module tb_kalman_gain_divider;
  import kalman_gain_div_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] num;
  logic [31:0] den;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] k_tdata;
  logic [1:0]  k_tuser;
  logic        k_tvalid;
  logic        k_tready;

  int checks = 0;
  int errors = 0;

`ifdef KGAIN_DIV_CLAMP_EN
  localparam logic [31:0] SAT_EXP     = ONE_Q[31:0];
  localparam logic [31:0] TEN3_EXP    = 32'h0100_0000;
  localparam logic [1:0]  TEN3_USER   = 2'b10;
`else
  localparam logic [31:0] SAT_EXP     = 32'hFFFF_FFFF;
  localparam logic [31:0] TEN3_EXP    = 32'h0355_5555;
  localparam logic [1:0]  TEN3_USER   = 2'b00;
`endif

  kalman_gain_divider dut (
    .clk               (clk),
    .rst               (rst),
    .S_AXIS_NUM_tdata  (num),
    .S_AXIS_DEN_tdata  (den),
    .S_AXIS_DIV_tvalid (s_tvalid),
    .S_AXIS_DIV_tready (s_tready),
    .M_AXIS_K_tdata    (k_tdata),
    .M_AXIS_K_tuser    (k_tuser),
    .M_AXIS_K_tvalid   (k_tvalid),
    .M_AXIS_K_tready   (k_tready)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Present one operand pair and return just after the accepting edge
  task automatic send(input logic [31:0] n, input logic [31:0] d);
    int guard = 0;
    while (!s_tready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) begin
      checks++; errors++;
      $display("FAIL send_timeout: tready never rose");
    end
    num = n; den = d; s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  // Count edges from the accept until tvalid is seen (bounded)
  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!k_tvalid && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic consume();
    k_tready = 1'b1;
    @(posedge clk); #1;
    k_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b exp 0", s_tready); end
    checks++; if (k_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", k_tvalid); end
    checks++; if (k_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h exp 0", k_tdata); end
    checks++; if (k_tuser !== 2'b00) begin errors++; $display("FAIL reset_tuser got %b exp 00", k_tuser); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_release_tready got %b exp 1", s_tready); end
  endtask

  task automatic test_half();
    int cyc;
    send(32'd1, 32'd2);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL half_busy_tready got %b exp 0", s_tready); end
    wait_out(cyc);
    checks++; if (cyc != ITER + 1) begin errors++; $display("FAIL half_latency got %0d exp %0d", cyc, ITER + 1); end
    checks++; if (k_tdata !== 32'h0080_0000) begin errors++; $display("FAIL half_data got %h exp 00800000", k_tdata); end
    checks++; if (k_tuser !== 2'b00) begin errors++; $display("FAIL half_tuser got %b exp 00", k_tuser); end
    consume();
  endtask

  task automatic test_fractions();
    int cyc;
    send(32'd3, 32'd4);
    wait_out(cyc);
    checks++; if (k_tdata !== 32'h00C0_0000) begin errors++; $display("FAIL frac34_data got %h exp 00c00000", k_tdata); end
    checks++; if (k_tuser !== 2'b00) begin errors++; $display("FAIL frac34_tuser got %b exp 00", k_tuser); end
    consume();
    send(32'h000A_0000, 32'h0003_0000);
    wait_out(cyc);
    checks++; if (k_tdata !== TEN3_EXP) begin errors++; $display("FAIL frac103_data got %h exp %h", k_tdata, TEN3_EXP); end
    checks++; if (k_tuser !== TEN3_USER) begin errors++; $display("FAIL frac103_tuser got %b exp %b", k_tuser, TEN3_USER); end
    consume();
  endtask

  task automatic test_div_zero();
    int cyc;
    send(32'd5, 32'd0);
    wait_out(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL dbz_latency got %0d exp 1", cyc); end
    checks++; if (k_tdata !== SAT_EXP) begin errors++; $display("FAIL dbz_data got %h exp %h", k_tdata, SAT_EXP); end
    checks++; if (k_tuser !== 2'b01) begin errors++; $display("FAIL dbz_tuser got %b exp 01", k_tuser); end
    consume();
  endtask

  task automatic test_saturation();
    int cyc;
    send(32'h8000_0000, 32'd1);
    wait_out(cyc);
    checks++; if (k_tdata !== SAT_EXP) begin errors++; $display("FAIL sat_data got %h exp %h", k_tdata, SAT_EXP); end
    checks++; if (k_tuser !== 2'b10) begin errors++; $display("FAIL sat_tuser got %b exp 10", k_tuser); end
    consume();
  endtask

  task automatic test_back_to_back();
    int cyc;
    int bad = 0;
    send(32'd1, 32'd2);
    wait_out(cyc);
    // Offer a second pair while the result is stalled; it must not be taken early
    num = 32'd3; den = 32'd4; s_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (k_tdata !== 32'h0080_0000 || k_tuser !== 2'b00 || k_tvalid !== 1'b1 || s_tready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
    k_tready = 1'b1;
    @(posedge clk); #1;
    k_tready = 1'b0;
    checks++; if (s_tready !== 1'b1 || k_tvalid !== 1'b0) begin errors++; $display("FAIL bp_idle got tready=%b tvalid=%b exp 1 0", s_tready, k_tvalid); end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_accept got tready=%b exp 0", s_tready); end
    wait_out(cyc);
    checks++; if (cyc != ITER + 1) begin errors++; $display("FAIL bp_next_latency got %0d exp %0d", cyc, ITER + 1); end
    checks++; if (k_tdata !== 32'h00C0_0000) begin errors++; $display("FAIL bp_next_data got %h exp 00c00000", k_tdata); end
    consume();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen = 0;
    send(32'd3, 32'd4);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({s_tready, k_tvalid, k_tdata, k_tuser} !== 36'h0) begin errors++; $display("FAIL midrst_outputs got %b %b %h %b exp zeros", s_tready, k_tvalid, k_tdata, k_tuser); end
    @(posedge clk); @(posedge clk); #1;
    checks++; if ({s_tready, k_tvalid, k_tdata, k_tuser} !== 36'h0) begin errors++; $display("FAIL midrst_hold got %b %b %h %b exp zeros", s_tready, k_tvalid, k_tdata, k_tuser); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL midrst_release_tready got %b exp 1", s_tready); end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (k_tvalid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_stale_result got %0d valid cycles exp 0", seen); end
    send(32'd1, 32'd2);
    wait_out(cyc);
    checks++; if (cyc != ITER + 1) begin errors++; $display("FAIL midrst_fresh_latency got %0d exp %0d", cyc, ITER + 1); end
    checks++; if (k_tdata !== 32'h0080_0000 || k_tuser !== 2'b00) begin errors++; $display("FAIL midrst_fresh_data got %h/%b exp 00800000/00", k_tdata, k_tuser); end
    consume();
  endtask

  initial begin
    rst = 1'b1; num = 32'h0; den = 32'h0; s_tvalid = 1'b0; k_tready = 1'b0;
    test_reset();
    test_half();
    test_fractions();
    test_div_zero();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
